// File: rtl/async_fifo.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg / async_fifo
//
// Purpose: single-clock FIFO with 16-bit words and 512 entries. Read and write
// pointers carry one extra wrap bit and are mirrored in gray code. The flags
// are decoded only from the gray copies, so the block can later be split into
// two clock domains without rewriting the flag logic.
//
// Ports:
//   clk         in   single clock, all state changes on the rising edge
//   reset       in   synchronous, active-high; overrides every other input
//   write_en    in   write request, accepted when fifo_full is low
//   data_in     in   write data (DATA_LEN bits)
//   read_en     in   read request, accepted when fifo_empty is low
//   data_out    out  registered read data, valid the cycle after a read
//   fifo_full   out  FIFO_DEPTH words stored
//   fifo_empty  out  no words stored
//
// Handshake: write_en and read_en are plain requests with no ready signal;
// the flags sampled at the start of a cycle decide acceptance, and a request
// made against a full (write) or empty (read) FIFO is dropped without effect.
// ---------------------------------------------------------------------------

package async_fifo_pkg;

    // The helpers work on 32-bit values. A zero-extended pointer converts
    // exactly, so a caller casts the result back to its own pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bit i of the binary value is the XOR of all gray bits from the MSB to i.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_LEN   = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int PNTR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_en,
    input  logic [DATA_LEN-1:0] data_in,
    input  logic                read_en,
    output logic [DATA_LEN-1:0] data_out,
    output logic                fifo_full,
    output logic                fifo_empty
);

    localparam int PW = PNTR_WIDTH + 1;

    logic [DATA_LEN-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0]       write_pointer_q, write_pointer_d;
    logic [PW-1:0]       read_pointer_q,  read_pointer_d;
    logic [PW-1:0]       wptr_gray_q,     wptr_gray_d;
    logic [PW-1:0]       rptr_gray_q,     rptr_gray_d;
    logic [PW-1:0]       read_pointer_bin_wrclk_q;
    logic [PW-1:0]       write_pointer_bin_rdclk_q;
    logic [DATA_LEN-1:0] data_out_q,      data_out_d;

    logic wr_accept;
    logic rd_accept;

    // Flags come from the registered gray pointers only.
    assign fifo_empty = (wptr_gray_q == rptr_gray_q);
    // Full in gray: top two bits inverted, the rest equal (binary: equal
    // except the wrap bit).
    assign fifo_full  = (wptr_gray_q[PW-1:PW-2] == ~rptr_gray_q[PW-1:PW-2]) &&
                        (wptr_gray_q[PW-3:0]    ==  rptr_gray_q[PW-3:0]);

    // Reset wins over requests, so nothing is accepted during a reset cycle.
    assign wr_accept = write_en && !fifo_full  && !reset;
    assign rd_accept = read_en  && !fifo_empty && !reset;

    always_comb begin
        write_pointer_d = write_pointer_q;
        read_pointer_d  = read_pointer_q;
        data_out_d      = data_out_q;
        if (wr_accept) begin
            write_pointer_d = write_pointer_q + PW'(1);
        end
        if (rd_accept) begin
            read_pointer_d = read_pointer_q + PW'(1);
            data_out_d     = mem[read_pointer_q[PNTR_WIDTH-1:0]];
        end
        wptr_gray_d = PW'(bin2gray(32'(write_pointer_d)));
        rptr_gray_d = PW'(bin2gray(32'(read_pointer_d)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_pointer_q           <= '0;
            read_pointer_q            <= '0;
            wptr_gray_q               <= '0;
            rptr_gray_q               <= '0;
            read_pointer_bin_wrclk_q  <= '0;
            write_pointer_bin_rdclk_q <= '0;
            data_out_q                <= '0;
        end else begin
            write_pointer_q           <= write_pointer_d;
            read_pointer_q            <= read_pointer_d;
            wptr_gray_q               <= wptr_gray_d;
            rptr_gray_q               <= rptr_gray_d;
            // Debug mirrors: decoded from the registered gray pointers, so
            // each lags its source pointer by one cycle.
            read_pointer_bin_wrclk_q  <= PW'(gray2bin(32'(rptr_gray_q)));
            write_pointer_bin_rdclk_q <= PW'(gray2bin(32'(wptr_gray_q)));
            data_out_q                <= data_out_d;
        end
    end

    // Storage is deliberately not reset; reads are blocked while empty, so
    // stale contents never reach data_out.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[write_pointer_q[PNTR_WIDTH-1:0]] <= data_in;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;
  import async_fifo_pkg::*;

  localparam int DEPTH = 512;
  localparam int PMOD  = 2 * DEPTH;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [15:0] data_in;
  logic        read_en;
  logic [15:0] data_out;
  logic        fifo_full;
  logic        fifo_empty;

  always #5 clk = ~clk;

  async_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .data_in    (data_in),
    .read_en    (read_en),
    .data_out   (data_out),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a queue of stored words plus running counts
  logic [15:0] exp_q[$];
  logic [15:0] m_dout = '0;
  int m_wp = 0, m_rp = 0, m_wmir = 0, m_rmir = 0;

  always @(posedge clk) begin
    int cnt;
    if (reset) begin
      exp_q.delete();
      m_wp = 0; m_rp = 0; m_wmir = 0; m_rmir = 0; m_dout = '0;
    end else begin
      m_wmir = m_wp;
      m_rmir = m_rp;
      cnt = exp_q.size();
      if (read_en && cnt > 0) begin
        m_dout = exp_q.pop_front();
        m_rp = (m_rp + 1) % PMOD;
      end
      if (write_en && cnt < DEPTH) begin
        exp_q.push_back(data_in);
        m_wp = (m_wp + 1) % PMOD;
      end
    end
  end

  // compare process: every cycle once the first reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out",   32'(data_out),   32'(m_dout));
      check("fifo_empty", 32'(fifo_empty), 32'(exp_q.size() == 0));
      check("fifo_full",  32'(fifo_full),  32'(exp_q.size() == DEPTH));
      check("write_ptr",  32'(dut.write_pointer_q), 32'(m_wp));
      check("read_ptr",   32'(dut.read_pointer_q),  32'(m_rp));
      check("wr_mirror",  32'(dut.write_pointer_bin_rdclk_q), 32'(m_wmir));
      check("rd_mirror",  32'(dut.read_pointer_bin_wrclk_q),  32'(m_rmir));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic we, input logic [15:0] d, input logic re);
    reset = rst; write_en = we; data_in = d; read_en = re;
    tick();
  endtask

  int gray_vec [10] = '{0, 10, 51, 511, 1, 45, 100, 101, 250, 513};

  initial begin
    logic [31:0] g10_exp;
    reset = 1'b1; write_en = 1'b0; data_in = '0; read_en = 1'b0;

    // gray helpers
    foreach (gray_vec[k]) begin
      check("gray_roundtrip", gray2bin(bin2gray(32'(gray_vec[k]))), 32'(gray_vec[k]));
    end
    g10_exp = 32'b0000001111;
    check("bin2gray_10", bin2gray(32'd10), g10_exp);

    // reset state
    tick();
    chk_en = 1'b1;
    drive(1, 0, 0, 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full",  32'(fifo_full),  0);
    check("rst_dout",  32'(data_out),   0);

    // fill then overflow: 513 attempts, then DEAD
    for (int i = 0; i <= DEPTH; i++) begin
      drive(0, 1, 16'(i), 0);
      if (i == DEPTH - 2) check("full_before_512", 32'(fifo_full), 0);
      if (i == DEPTH - 1) check("full_at_512",     32'(fifo_full), 1);
    end
    drive(0, 1, 16'hDEAD, 0);
    check("fill_wptr",      32'(dut.write_pointer_q), 512);
    check("fill_full",      32'(fifo_full), 1);
    check("model_fill_cnt", 32'(exp_q.size()), 512);

    // drain: 517 reads
    for (int i = 0; i < DEPTH + 5; i++) begin
      drive(0, 0, 0, 1);
      if (i == 0) begin
        check("drain_first",     32'(data_out),  0);
        check("drain_full_drop", 32'(fifo_full), 0);
      end
      if (i == 100)       check("drain_100",   32'(data_out), 100);
      if (i == DEPTH - 2) check("drain_nonempty", 32'(fifo_empty), 0);
      if (i == DEPTH - 1) check("drain_empty", 32'(fifo_empty), 1);
      if (i >= DEPTH - 1) check("drain_hold",  32'(data_out), 511);
    end

    // read when empty
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1);
      check("empty_rd_dout",  32'(data_out), 0);
      check("empty_rd_rptr",  32'(dut.read_pointer_q), 0);
      check("empty_rd_empty", 32'(fifo_empty), 1);
    end

    // wrap-around with simultaneous access at half full
    drive(1, 0, 0, 0);
    for (int i = 0; i < DEPTH / 2; i++) drive(0, 1, 16'(16'h1000 + i), 0);
    for (int i = 0; i < 1500; i++) drive(0, 1, 16'(i * 37 + 5), 1);
    check("wrap_not_empty", 32'(fifo_empty), 0);
    check("wrap_not_full",  32'(fifo_full),  0);
    check("model_wrap_cnt", 32'(exp_q.size()), 256);
    for (int i = 0; i < DEPTH / 2; i++) drive(0, 1, 16'(16'h2000 + i), 0);
    check("wrap_full", 32'(fifo_full), 1);
    drive(0, 1, 16'hBEEF, 1);
    check("both_full_rd_ok", 32'(fifo_full), 0);
    check("both_full_wptr",  32'(dut.write_pointer_q), 988);
    check("both_full_rptr",  32'(dut.read_pointer_q),  477);

    // reset mid-operation
    drive(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) drive(0, 1, 16'(i + 16'h0300), 0);
    drive(1, 0, 0, 0);
    check("midrst_empty", 32'(fifo_empty), 1);
    check("midrst_wptr",  32'(dut.write_pointer_q), 0);
    check("midrst_rptr",  32'(dut.read_pointer_q),  0);
    drive(0, 1, 16'h1234, 0);
    drive(0, 0, 0, 1);
    check("midrst_data", 32'(data_out), 32'h1234);
    drive(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
